csr_trap_ctrl: RTL and testbench
================================

# csr_trap_ctrl

Sequencer and arbiter for the single-write-port CSR file. It serves three requesters: CSR instructions (CSRRW/CSRRS/CSRRC), synchronous traps, and MRET. For a trap or MRET it runs the multi-cycle update of mepc, mcause, mtval and mstatus, then issues a PC redirect. It sits between the execute stage and `csr_file`, and it is the only block that drives that file's write port.

## Interface
Parameters:
- `XLEN`, default 32: data width; matches `data_t`.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `csr_valid`, in, 1: CSR instruction request; held until `csr_ready`.
- `csr_op`, in, `csr_op_t`: CSR_RW, CSR_RS or CSR_RC.
- `csr_addr`, in, `csr_addr_t`: target CSR.
- `csr_src`, in, `XLEN`: rs1 value or zero-extended uimm.
- `csr_no_wr`, in, 1: decoder flag, set when rs1/uimm field is x0 for RS/RC.
- `csr_ready`, out, 1: request completed this cycle.
- `csr_old`, out, `XLEN`: pre-write CSR value, for rd.
- `trap_valid`, in, 1: trap request; held until `trap_ready`.
- `trap_cause`, in, `XLEN`: mcause value (bit 31 is the interrupt flag).
- `trap_epc`, in, `XLEN`: faulting PC.
- `trap_tval`, in, `XLEN`: mtval value.
- `trap_ready`, out, 1: trap accepted.
- `mret_valid`, in, 1: MRET request; held until `mret_ready`.
- `mret_ready`, out, 1: MRET accepted.
- `cf_we`, out, 1: csr_file write enable.
- `cf_addr`, out, `csr_addr_t`: csr_file address (read and write).
- `cf_wdata`, out, `XLEN`: csr_file write data.
- `cf_rdata`, in, `XLEN`: csr_file combinational read data.
- `cf_mtvec`, in, `XLEN`: mtvec tap from csr_file.
- `cf_mepc`, in, `XLEN`: mepc tap from csr_file.
- `busy`, out, 1: sequence in progress; the pipeline stalls.
- `redirect_valid`, out, 1: one-cycle PC redirect pulse.
- `redirect_pc`, out, `XLEN`: redirect target.

## Operation
FSM states: IDLE, T_EPC, T_CAUSE, T_TVAL, T_STAT, M_STAT, REDIR.

IDLE arbitration, highest priority first: trap, then MRET, then CSR.
- **Trap:** assert `trap_ready`; latch cause/epc/tval; go to T_EPC.
- **MRET:** assert `mret_ready`; go to M_STAT.
- **CSR:** completes in the same cycle.
  - `cf_addr = csr_addr`; `csr_old = cf_rdata`; `csr_ready = 1`.
  - Write value: RW gives src; RS gives old | src; RC gives old & ~src.
  - `cf_we = 1` unless `csr_no_wr` is set and the op is RS or RC.

Trap sequence, one write per state:
- T_EPC writes mepc = {epc[31:2], 2'b00}.
- T_CAUSE writes mcause.
- T_TVAL writes mtval.
- T_STAT reads mstatus and writes it back with MPIE = MIE, MIE = 0, MPP = 2'b11; then goes to REDIR.

MRET sequence:
- M_STAT reads mstatus and writes it back with MIE = MPIE, MPIE = 1, MPP = 2'b11; then goes to REDIR.

REDIR:
- Pulses `redirect_valid`, then returns to IDLE.
- After a trap, the target comes from mtvec:
  - Direct mode (mtvec[1:0] = 00): target is {mtvec[31:2], 2'b00}.
  - Vectored mode (01) with cause bit 31 set: target is base + (cause[30:0] << 2), truncated to XLEN.
  - Exceptions always use base.
  - mtvec[1:0] values 10 and 11 are treated as direct.
- After MRET, the target is `cf_mepc`.

Behaviour outside IDLE:
- `busy` = (state != IDLE).
- No ready signal is asserted; requests are held, not dropped.

## Timing
- Reset values: state IDLE. All outputs are 0 (`cf_we`, `cf_addr`, `cf_wdata`, all readies, `busy`, `redirect_valid`, `redirect_pc`, `csr_old`).
- CSR op: 0-cycle latency, combinational. The write lands at the next clk edge.
- Trap: accepted in cycle T.
  - Writes occur in T+1 (mepc), T+2 (mcause), T+3 (mtval), T+4 (mstatus).
  - `redirect_valid` pulses in T+5.
  - `busy` is high for T+1 through T+5.
- MRET: accepted in cycle T; mstatus write in T+1; redirect in T+2.
- Redirect after a trap uses mtvec sampled in REDIR, so a CSR write to mtvec made before the trap is visible.
- Simultaneous `trap_valid` and `mret_valid` and `csr_valid`: only the trap is acked. The others stay pending until IDLE is next reached.
- `rst` mid-sequence: next state is IDLE. No further CSR writes and no redirect are issued; writes already committed remain.
- Back-to-back: a request held through REDIR is accepted in the first IDLE cycle after it.

## Structure
- `csr_addr_pkg`: add CSR_ADDR_MSTATUS, CSR_ADDR_MCAUSE, CSR_ADDR_MTVAL alongside the existing MTVEC and MEPC constants.
- `type_pkg`: add `csr_op_t` (CSR_RW, CSR_RS, CSR_RC) and mstatus bit-position constants (MIE = 3, MPIE = 7, MPP = 12:11).
- The FSM state enum is local to the module.
- One combinational sub-module, `csr_alu`: computes the RW/RS/RC result and the write-suppress decision.

## Test plan
- **CSRRW:** RW to 0x340 with src 0xDEADBEEF, old value 0.
  - Same cycle: `csr_ready = 1`, `csr_old = 0`, `cf_we = 1`, `cf_wdata = 0xDEADBEEF`.
- **RS with x0 suppress:** RS to 0x340, `csr_no_wr = 1`, CSR holds 0x5.
  - `csr_old = 5`, `cf_we = 0`.
- **RC:** RC with src 0x4 on CSR value 0xF.
  - `cf_wdata = 0xB`.
- **Trap, direct mode:** mtvec = 0x100, mstatus.MIE = 1, cause 2, epc 0x8000_0042, tval 0x13.
  - mepc = 0x8000_0040, mcause = 2, mtval = 0x13.
  - mstatus: MIE = 0, MPIE = 1, MPP = 3.
  - `redirect_pc = 0x100` exactly at T+5.
- **Trap, vectored interrupt:** mtvec = 0x101, cause 0x8000_0007.
  - `redirect_pc = 0x11C`.
- **Arbitration, reset, MRET:**
  - Trap, MRET and CSR requests all arrive in the same cycle: only `trap_ready` is asserted. MRET is acked at T+6; CSR completes at T+9.
  - `rst` asserted at T+2 of a trap: only mepc was written, no redirect, all outputs 0 next cycle.
  - MRET with MPIE = 1: MIE = 1, `redirect_pc` = mepc at T+2.

Source files
------------

// File: rtl/csr_addr_pkg.sv
// Machine-mode CSR addresses known to the trap sequencer.
package csr_addr_pkg;

    typedef logic [11:0] csr_addr_t;

    localparam csr_addr_t CSR_ADDR_MSTATUS = 12'h300;
    localparam csr_addr_t CSR_ADDR_MTVEC   = 12'h305;
    localparam csr_addr_t CSR_ADDR_MEPC    = 12'h341;
    localparam csr_addr_t CSR_ADDR_MCAUSE  = 12'h342;
    localparam csr_addr_t CSR_ADDR_MTVAL   = 12'h343;

endpackage

// File: rtl/type_pkg.sv
// Shared scalar types and architectural bit positions used by the CSR path.
package type_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef logic [XLEN_DEFAULT-1:0] data_t;

    // CSR instruction flavours; the encoding of csr_op_t has one unused value.
    typedef enum logic [1:0] {
        CSR_RW = 2'd0,
        CSR_RS = 2'd1,
        CSR_RC = 2'd2
    } csr_op_t;

    // mstatus bit positions touched by trap entry and MRET.
    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

endpackage

// File: rtl/csr_alu.sv
// Read-modify-write datapath for CSRRW/CSRRS/CSRRC, including the x0
// write-suppress rule for the set/clear forms.
module csr_alu
    import type_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  csr_op_t         op,
    input  logic [XLEN-1:0] old_val,
    input  logic [XLEN-1:0] src,
    input  logic            no_wr,
    output logic [XLEN-1:0] result,
    output logic            we
);

    // Select the new CSR value and whether it should be written at all.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        result = old_val;
        we     = 1'b0;
        case (op)
            CSR_RW: begin
                result = src;
                we     = 1'b1;
            end
            CSR_RS: begin
                result = old_val | src;
                we     = !no_wr;
            end
            CSR_RC: begin
                result = old_val & ~src;
                we     = !no_wr;
            end
            default: begin
                result = old_val;
                we     = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/csr_trap_ctrl.sv
// Arbiter and sequencer owning the csr_file write port: single-cycle CSR
// instructions, multi-cycle trap entry and MRET, followed by a PC redirect.
module csr_trap_ctrl
    import type_pkg::*;
    import csr_addr_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            csr_valid,
    input  csr_op_t         csr_op,
    input  csr_addr_t       csr_addr,
    input  logic [XLEN-1:0] csr_src,
    input  logic            csr_no_wr,
    output logic            csr_ready,
    output logic [XLEN-1:0] csr_old,

    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_epc,
    input  logic [XLEN-1:0] trap_tval,
    output logic            trap_ready,

    input  logic            mret_valid,
    output logic            mret_ready,

    output logic            cf_we,
    output csr_addr_t       cf_addr,
    output logic [XLEN-1:0] cf_wdata,
    input  logic [XLEN-1:0] cf_rdata,
    input  logic [XLEN-1:0] cf_mtvec,
    input  logic [XLEN-1:0] cf_mepc,

    output logic            busy,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    typedef enum logic [2:0] {
        IDLE,
        T_EPC,
        T_CAUSE,
        T_TVAL,
        T_STAT,
        M_STAT,
        REDIR
    } state_t;

    state_t          state;
    logic [XLEN-1:0] cause_q;
    logic [XLEN-1:0] epc_q;
    logic [XLEN-1:0] tval_q;
    logic            from_trap_q;

    logic [XLEN-1:0] alu_result;
    logic            alu_we;
    logic [XLEN-1:0] mtvec_base;
    logic [XLEN-1:0] trap_target;

    csr_alu #(.XLEN(XLEN)) u_csr_alu (
        .op      (csr_op),
        .old_val (cf_rdata),
        .src     (csr_src),
        .no_wr   (csr_no_wr),
        .result  (alu_result),
        .we      (alu_we)
    );

    // Sequencer state and the trap fields captured at acceptance.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with <= so every reader in this cycle sees the pre-edge value.
        if (rst) begin
            // NOTE: only control state is reset; the latched trap fields are always written before they are read.
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (trap_valid) begin
                        cause_q     <= trap_cause;
                        epc_q       <= {trap_epc[XLEN-1:2], 2'b00};
                        tval_q      <= trap_tval;
                        from_trap_q <= 1'b1;
                        state       <= T_EPC;
                    end else if (mret_valid) begin
                        from_trap_q <= 1'b0;
                        state       <= M_STAT;
                    end
                end
                T_EPC:   state <= T_CAUSE;
                T_CAUSE: state <= T_TVAL;
                T_TVAL:  state <= T_STAT;
                T_STAT:  state <= REDIR;
                M_STAT:  state <= REDIR;
                REDIR:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Trap vector: base from mtvec as seen in REDIR, offset only for vectored interrupts.
    always_comb begin
        mtvec_base  = {cf_mtvec[XLEN-1:2], 2'b00};
        trap_target = mtvec_base;
        if (cf_mtvec[1:0] == 2'b01 && cause_q[XLEN-1]) begin
            trap_target = mtvec_base + {cause_q[XLEN-3:0], 2'b00};
        end
    end

    // Output decode; reset forces everything quiet so a sequence cut short commits nothing more.
    always_comb begin
        csr_ready      = 1'b0;
        csr_old        = '0;
        trap_ready     = 1'b0;
        mret_ready     = 1'b0;
        cf_we          = 1'b0;
        cf_addr        = '0;
        cf_wdata       = '0;
        busy           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if (!rst) begin
            busy = (state != IDLE);
            case (state)
                IDLE: begin
                    if (trap_valid) begin
                        trap_ready = 1'b1;
                    end else if (mret_valid) begin
                        mret_ready = 1'b1;
                    end else if (csr_valid) begin
                        csr_ready = 1'b1;
                        cf_addr   = csr_addr;
                        csr_old   = cf_rdata;
                        cf_we     = alu_we;
                        cf_wdata  = alu_result;
                    end
                end
                T_EPC: begin
                    cf_we    = 1'b1;
                    cf_addr  = CSR_ADDR_MEPC;
                    cf_wdata = epc_q;
                end
                T_CAUSE: begin
                    cf_we    = 1'b1;
                    cf_addr  = CSR_ADDR_MCAUSE;
                    cf_wdata = cause_q;
                end
                T_TVAL: begin
                    cf_we    = 1'b1;
                    cf_addr  = CSR_ADDR_MTVAL;
                    cf_wdata = tval_q;
                end
                T_STAT: begin
                    cf_we    = 1'b1;
                    cf_addr  = CSR_ADDR_MSTATUS;
                    cf_wdata = cf_rdata;
                    cf_wdata[MSTATUS_MPIE] = cf_rdata[MSTATUS_MIE];
                    cf_wdata[MSTATUS_MIE]  = 1'b0;
                    cf_wdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
                end
                M_STAT: begin
                    cf_we    = 1'b1;
                    cf_addr  = CSR_ADDR_MSTATUS;
                    cf_wdata = cf_rdata;
                    cf_wdata[MSTATUS_MIE]  = cf_rdata[MSTATUS_MPIE];
                    cf_wdata[MSTATUS_MPIE] = 1'b1;
                    cf_wdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
                end
                REDIR: begin
                    redirect_valid = 1'b1;
                    redirect_pc    = from_trap_q ? trap_target : cf_mepc;
                end
                default: begin
                    busy = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Directed bench for csr_trap_ctrl with a behavioural csr_file next to it.
module tb_csr_trap_ctrl;
    import type_pkg::*;
    import csr_addr_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        csr_valid;
    csr_op_t     csr_op;
    csr_addr_t   csr_addr;
    logic [31:0] csr_src;
    logic        csr_no_wr;
    logic        csr_ready;
    logic [31:0] csr_old;
    logic        trap_valid;
    logic [31:0] trap_cause;
    logic [31:0] trap_epc;
    logic [31:0] trap_tval;
    logic        trap_ready;
    logic        mret_valid;
    logic        mret_ready;
    logic        cf_we;
    csr_addr_t   cf_addr;
    logic [31:0] cf_wdata;
    logic [31:0] cf_rdata;
    logic [31:0] cf_mtvec;
    logic [31:0] cf_mepc;
    logic        busy;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Behavioural csr_file: combinational read, write on the clock edge, plus a backdoor preload.
    logic [31:0] csr_mem [4096];
    logic        poke_en;
    csr_addr_t   poke_addr;
    logic [31:0] poke_data;

    always @(posedge clk) begin
        if (cf_we) csr_mem[cf_addr] <= cf_wdata;
        else if (poke_en) csr_mem[poke_addr] <= poke_data;
    end

    assign cf_rdata = csr_mem[cf_addr];
    assign cf_mtvec = csr_mem[CSR_ADDR_MTVEC];
    assign cf_mepc  = csr_mem[CSR_ADDR_MEPC];

    csr_trap_ctrl #(.XLEN(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .csr_valid      (csr_valid),
        .csr_op         (csr_op),
        .csr_addr       (csr_addr),
        .csr_src        (csr_src),
        .csr_no_wr      (csr_no_wr),
        .csr_ready      (csr_ready),
        .csr_old        (csr_old),
        .trap_valid     (trap_valid),
        .trap_cause     (trap_cause),
        .trap_epc       (trap_epc),
        .trap_tval      (trap_tval),
        .trap_ready     (trap_ready),
        .mret_valid     (mret_valid),
        .mret_ready     (mret_ready),
        .cf_we          (cf_we),
        .cf_addr        (cf_addr),
        .cf_wdata       (cf_wdata),
        .cf_rdata       (cf_rdata),
        .cf_mtvec       (cf_mtvec),
        .cf_mepc        (cf_mepc),
        .busy           (busy),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Move to the start of the next cycle, just after the active edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input csr_addr_t addr, input logic [31:0] data);
        next_cycle();
        poke_en   = 1'b1;
        poke_addr = addr;
        poke_data = data;
        @(posedge clk);
        #1;
        poke_en = 1'b0;
    endtask

    task automatic set_csr(input csr_op_t op, input csr_addr_t addr,
                           input logic [31:0] src, input logic no_wr);
        csr_valid = 1'b1;
        csr_op    = op;
        csr_addr  = addr;
        csr_src   = src;
        csr_no_wr = no_wr;
    endtask

    task automatic check_all_quiet(input string tag);
        check({tag, "_busy"},   32'(busy), 0);
        check({tag, "_we"},     32'(cf_we), 0);
        check({tag, "_addr"},   32'(cf_addr), 0);
        check({tag, "_wdata"},  cf_wdata, 0);
        check({tag, "_redir"},  32'(redirect_valid), 0);
        check({tag, "_rpc"},    redirect_pc, 0);
        check({tag, "_tready"}, 32'(trap_ready), 0);
        check({tag, "_mready"}, 32'(mret_ready), 0);
        check({tag, "_cready"}, 32'(csr_ready), 0);
        check({tag, "_old"},    csr_old, 0);
    endtask

    // Full trap: accept in T, four writes in T+1..T+4, redirect in T+5, idle in T+6.
    task automatic run_trap(input string tag, input logic [31:0] cause,
                            input logic [31:0] epc, input logic [31:0] tval,
                            input logic [31:0] exp_pc);
        csr_addr_t   exp_addr [4];
        logic [31:0] exp_data [3];
        exp_addr[0] = CSR_ADDR_MEPC;
        exp_addr[1] = CSR_ADDR_MCAUSE;
        exp_addr[2] = CSR_ADDR_MTVAL;
        exp_addr[3] = CSR_ADDR_MSTATUS;
        exp_data[0] = epc & 32'hFFFF_FFFC;
        exp_data[1] = cause;
        exp_data[2] = tval;
        next_cycle();
        trap_valid = 1'b1;
        trap_cause = cause;
        trap_epc   = epc;
        trap_tval  = tval;
        @(negedge clk);
        check({tag, "_ack"}, 32'(trap_ready), 1);
        check({tag, "_busyT"}, 32'(busy), 0);
        next_cycle();
        trap_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check({tag, "_busy"}, 32'(busy), 1);
            check({tag, "_we"}, 32'(cf_we), 1);
            check({tag, "_addr"}, 32'(cf_addr), 32'(exp_addr[i]));
            if (i < 3) check({tag, "_wdata"}, cf_wdata, exp_data[i]);
            check({tag, "_noredir"}, 32'(redirect_valid), 0);
            next_cycle();
        end
        @(negedge clk);
        check({tag, "_redir"}, 32'(redirect_valid), 1);
        check({tag, "_pc"}, redirect_pc, exp_pc);
        check({tag, "_busy5"}, 32'(busy), 1);
        check({tag, "_we5"}, 32'(cf_we), 0);
        next_cycle();
        @(negedge clk);
        check({tag, "_busy6"}, 32'(busy), 0);
        check({tag, "_redir6"}, 32'(redirect_valid), 0);
    endtask

    initial begin
        rst        = 1'b1;
        csr_valid  = 1'b0;
        csr_op     = CSR_RW;
        csr_addr   = '0;
        csr_src    = '0;
        csr_no_wr  = 1'b0;
        trap_valid = 1'b0;
        trap_cause = '0;
        trap_epc   = '0;
        trap_tval  = '0;
        mret_valid = 1'b0;
        poke_en    = 1'b0;
        poke_addr  = '0;
        poke_data  = '0;

        // Reset state.
        next_cycle();
        next_cycle();
        @(negedge clk);
        check_all_quiet("reset");
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check_all_quiet("idle");

        // CSRRW, old value 0.
        poke(12'h340, 32'h0);
        next_cycle();
        set_csr(CSR_RW, 12'h340, 32'hDEAD_BEEF, 1'b0);
        @(negedge clk);
        check("rw_ready", 32'(csr_ready), 1);
        check("rw_old", csr_old, 0);
        check("rw_we", 32'(cf_we), 1);
        check("rw_addr", 32'(cf_addr), 32'h340);
        check("rw_wdata", cf_wdata, 32'hDEAD_BEEF);
        next_cycle();
        csr_valid = 1'b0;
        check("rw_mem", csr_mem[12'h340], 32'hDEAD_BEEF);

        // CSRRS with x0 source: read only.
        poke(12'h340, 32'h5);
        next_cycle();
        set_csr(CSR_RS, 12'h340, 32'h0, 1'b1);
        @(negedge clk);
        check("rs0_ready", 32'(csr_ready), 1);
        check("rs0_old", csr_old, 32'h5);
        check("rs0_we", 32'(cf_we), 0);
        next_cycle();
        csr_valid = 1'b0;
        check("rs0_mem", csr_mem[12'h340], 32'h5);

        // CSRRC clears bit 2 of 0xF.
        poke(12'h340, 32'hF);
        next_cycle();
        set_csr(CSR_RC, 12'h340, 32'h4, 1'b0);
        @(negedge clk);
        check("rc_old", csr_old, 32'hF);
        check("rc_we", 32'(cf_we), 1);
        check("rc_wdata", cf_wdata, 32'hB);
        next_cycle();
        csr_valid = 1'b0;

        // CSRRS sets bits on 0xB.
        next_cycle();
        set_csr(CSR_RS, 12'h340, 32'h30, 1'b0);
        @(negedge clk);
        check("rs_we", 32'(cf_we), 1);
        check("rs_wdata", cf_wdata, 32'h3B);
        next_cycle();
        csr_valid = 1'b0;

        // Trap, direct mode, MIE set beforehand.
        poke(CSR_ADDR_MTVEC, 32'h100);
        poke(CSR_ADDR_MSTATUS, 32'h8);
        run_trap("tdir", 32'h2, 32'h8000_0042, 32'h13, 32'h100);
        check("tdir_mepc", csr_mem[CSR_ADDR_MEPC], 32'h8000_0040);
        check("tdir_mcause", csr_mem[CSR_ADDR_MCAUSE], 32'h2);
        check("tdir_mtval", csr_mem[CSR_ADDR_MTVAL], 32'h13);
        check("tdir_mstatus", csr_mem[CSR_ADDR_MSTATUS], 32'h0000_1880);

        // Vectored interrupt, vectored exception, and reserved mode 11.
        poke(CSR_ADDR_MTVEC, 32'h101);
        run_trap("tvec", 32'h8000_0007, 32'h1000, 32'h0, 32'h11C);
        check("tvec_mstatus", csr_mem[CSR_ADDR_MSTATUS], 32'h0000_1800);
        run_trap("tvexc", 32'h5, 32'h1004, 32'h0, 32'h100);
        poke(CSR_ADDR_MTVEC, 32'h103);
        run_trap("tres", 32'h8000_0003, 32'h1008, 32'h0, 32'h100);

        // Trap, MRET and CSR all at once.
        poke(CSR_ADDR_MTVEC, 32'h200);
        next_cycle();
        trap_valid = 1'b1;
        trap_cause = 32'hB;
        trap_epc   = 32'h3000;
        trap_tval  = 32'h0;
        mret_valid = 1'b1;
        set_csr(CSR_RW, 12'h340, 32'h55, 1'b0);
        @(negedge clk);
        check("arb_tready", 32'(trap_ready), 1);
        check("arb_mready0", 32'(mret_ready), 0);
        check("arb_cready0", 32'(csr_ready), 0);
        next_cycle();
        trap_valid = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            check("arb_mwait", 32'(mret_ready), 0);
            check("arb_cwait", 32'(csr_ready), 0);
            check("arb_tredir", 32'(redirect_valid), 32'(i == 5));
            next_cycle();
        end
        @(negedge clk);
        check("arb_mready6", 32'(mret_ready), 1);
        check("arb_cready6", 32'(csr_ready), 0);
        next_cycle();
        mret_valid = 1'b0;
        @(negedge clk);
        check("arb_cready7", 32'(csr_ready), 0);
        check("arb_maddr7", 32'(cf_addr), 32'(CSR_ADDR_MSTATUS));
        next_cycle();
        @(negedge clk);
        check("arb_mredir8", 32'(redirect_valid), 1);
        check("arb_mpc8", redirect_pc, 32'h3000);
        check("arb_cready8", 32'(csr_ready), 0);
        next_cycle();
        @(negedge clk);
        check("arb_cready9", 32'(csr_ready), 1);
        check("arb_cwdata9", cf_wdata, 32'h55);
        next_cycle();
        csr_valid = 1'b0;
        check("arb_cmem", csr_mem[12'h340], 32'h55);

        // Reset at T+2 of a trap: only mepc lands.
        poke(CSR_ADDR_MEPC, 32'h0);
        poke(CSR_ADDR_MCAUSE, 32'hAAAA);
        poke(CSR_ADDR_MTVAL, 32'hBBBB);
        next_cycle();
        trap_valid = 1'b1;
        trap_cause = 32'h5;
        trap_epc   = 32'h2006;
        trap_tval  = 32'h77;
        @(negedge clk);
        check("rsq_ack", 32'(trap_ready), 1);
        next_cycle();
        trap_valid = 1'b0;
        @(negedge clk);
        check("rsq_we1", 32'(cf_we), 1);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check("rsq_we2", 32'(cf_we), 0);
        check("rsq_busy2", 32'(busy), 0);
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_all_quiet("rsq_after");
            next_cycle();
        end
        check("rsq_mepc", csr_mem[CSR_ADDR_MEPC], 32'h2004);
        check("rsq_mcause", csr_mem[CSR_ADDR_MCAUSE], 32'hAAAA);
        check("rsq_mtval", csr_mem[CSR_ADDR_MTVAL], 32'hBBBB);

        // MRET with MPIE set.
        poke(CSR_ADDR_MSTATUS, 32'h80);
        poke(CSR_ADDR_MEPC, 32'h4000_0010);
        next_cycle();
        mret_valid = 1'b1;
        @(negedge clk);
        check("mret_ack", 32'(mret_ready), 1);
        check("mret_busy0", 32'(busy), 0);
        next_cycle();
        mret_valid = 1'b0;
        @(negedge clk);
        check("mret_we", 32'(cf_we), 1);
        check("mret_addr", 32'(cf_addr), 32'(CSR_ADDR_MSTATUS));
        check("mret_wdata", cf_wdata, 32'h0000_1888);
        check("mret_busy1", 32'(busy), 1);
        next_cycle();
        @(negedge clk);
        check("mret_redir", 32'(redirect_valid), 1);
        check("mret_pc", redirect_pc, 32'h4000_0010);
        next_cycle();
        @(negedge clk);
        check("mret_busy3", 32'(busy), 0);
        check("mret_redir3", 32'(redirect_valid), 0);
        check("mret_mstatus", csr_mem[CSR_ADDR_MSTATUS], 32'h0000_1888);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
